// File: rtl/bc_operand_feeder.sv
// Lane-0 broadcast operand feeder. It pops fp32 scalars from the broadcast buffer and replays
// each one, duplicated into both 32-bit halves, for a configured number of operand beats.
module bc_operand_feeder #(
    parameter int unsigned MAX_BLEN = 32,
    parameter int unsigned RepW     = 16,
    localparam int unsigned BlenW   = $clog2(MAX_BLEN) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [BlenW-1:0] cfg_blen_i,
    input  logic [RepW-1:0]  cfg_reps_i,
    input  logic             bc_valid_i,
    input  logic [63:0]      bc_data_i,
    output logic             bc_ready_o,
    output logic             bc_invalidate_o,
    output logic             opnd_valid_o,
    input  logic             opnd_ready_i,
    output logic [63:0]      opnd_data_o,
    output logic             opnd_last_o,
    output logic             done_o
);

    typedef enum logic [2:0] {StIdle, StFetch, StIssue, StInval, StZero} state_e;

    state_e           state_q, state_d;
    logic [31:0]      data_q, data_d;
    logic [RepW-1:0]  rep_q, rep_d, reps_q, reps_d;
    logic [BlenW-1:0] elem_q, elem_d, blen_q, blen_d;
    logic [BlenW-1:0] blen_sat;
    logic             last_rep, last_elem, prefetch;
    logic             unused_bc_hi;

    assign unused_bc_hi = ^bc_data_i[63:32];

    assign blen_sat  = (cfg_blen_i > BlenW'(MAX_BLEN)) ? BlenW'(MAX_BLEN) : cfg_blen_i;
    assign last_rep  = (rep_q == reps_q - RepW'(1));
    assign last_elem = (elem_q == blen_q - BlenW'(1));
    // Pop the next scalar while the final beat of the current one is accepted: no bubble.
    assign prefetch  = (state_q == StIssue) && opnd_ready_i && last_rep && !last_elem;

    assign cfg_ready_o     = (state_q == StIdle);
    assign bc_ready_o      = (state_q == StFetch) || (state_q == StInval) || prefetch;
    assign bc_invalidate_o = (state_q == StInval);
    assign opnd_valid_o    = (state_q == StIssue);
    assign opnd_data_o     = {data_q, data_q};
    assign opnd_last_o     = (state_q == StIssue) && last_rep && last_elem;
    assign done_o          = (state_q == StInval) || (state_q == StZero);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rep_d   = rep_q;
        elem_d  = elem_q;
        blen_d  = blen_q;
        reps_d  = reps_q;
        case (state_q)
            StIdle: begin
                if (cfg_valid_i) begin
                    if (blen_sat == '0 || cfg_reps_i == '0) begin
                        state_d = StZero;
                    end else begin
                        blen_d  = blen_sat;
                        reps_d  = cfg_reps_i;
                        rep_d   = '0;
                        elem_d  = '0;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (bc_valid_i) begin
                    data_d  = bc_data_i[31:0];
                    rep_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (opnd_ready_i) begin
                    rep_d = rep_q + RepW'(1);
                    if (last_rep) begin
                        elem_d = elem_q + BlenW'(1);
                        if (last_elem) begin
                            state_d = StInval;
                        end else if (bc_valid_i) begin
                            data_d = bc_data_i[31:0];
                            rep_d  = '0;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end
            end
            StInval, StZero: state_d = StIdle;
            default:         state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            data_q  <= '0;
            rep_q   <= '0;
            elem_q  <= '0;
            blen_q  <= '0;
            reps_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rep_q   <= rep_d;
            elem_q  <= elem_d;
            blen_q  <= blen_d;
            reps_q  <= reps_d;
        end
    end

endmodule

// File: tb/tb_bc_operand_feeder.sv
// Directed bench for bc_operand_feeder: a cycle table for the nominal round plus hand-written
// sequences for backpressure, starvation, degenerate configs, saturation and mid-round reset.
module tb_bc_operand_feeder;
    localparam int unsigned MaxBlen = 32;
    localparam int unsigned RepW    = 16;
    localparam int unsigned BlenW   = $clog2(MaxBlen) + 1;
    localparam logic [31:0] S0 = 32'h3F80_0000;
    localparam logic [31:0] S1 = 32'h4000_0000;
    localparam logic [31:0] S2 = 32'h4040_0000;
    localparam logic [31:0] Junk = 32'hDEAD_BEEF;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [BlenW-1:0] cfg_blen_i;
    logic [RepW-1:0]  cfg_reps_i;
    logic             bc_valid_i;
    logic [63:0]      bc_data_i;
    logic             bc_ready_o;
    logic             bc_invalidate_o;
    logic             opnd_valid_o;
    logic             opnd_ready_i;
    logic [63:0]      opnd_data_o;
    logic             opnd_last_o;
    logic             done_o;

    bc_operand_feeder #(
        .MAX_BLEN(MaxBlen),
        .RepW    (RepW)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_blen_i     (cfg_blen_i),
        .cfg_reps_i     (cfg_reps_i),
        .bc_valid_i     (bc_valid_i),
        .bc_data_i      (bc_data_i),
        .bc_ready_o     (bc_ready_o),
        .bc_invalidate_o(bc_invalidate_o),
        .opnd_valid_o   (opnd_valid_o),
        .opnd_ready_i   (opnd_ready_i),
        .opnd_data_o    (opnd_data_o),
        .opnd_last_o    (opnd_last_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // stim = {cfg_valid, bc_valid, opnd_ready}; flags = {cfg_rdy, bc_rdy, ov, last, inval, done}
    typedef struct packed {
        logic [2:0]  stim;
        logic [31:0] bc_d;
        logic [5:0]  flags;
        logic [31:0] scal;
    } vec_t;

    vec_t tv [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sc(input int i);
        return 32'h3F80_0000 + 32'(i) * 32'h0010_0000;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " cfg_ready"}, 64'(cfg_ready_o), 64'd1);
        check({tag, " bc_ready"}, 64'(bc_ready_o), 64'd0);
        check({tag, " bc_invalidate"}, 64'(bc_invalidate_o), 64'd0);
        check({tag, " opnd_valid"}, 64'(opnd_valid_o), 64'd0);
        check({tag, " opnd_last"}, 64'(opnd_last_o), 64'd0);
        check({tag, " done"}, 64'(done_o), 64'd0);
        check({tag, " opnd_data"}, opnd_data_o, 64'd0);
    endtask

    // Drives one round as the bc source and operand sink; checks beats, pops and handshakes.
    task automatic run_round(input int blen_cfg, input int reps_cfg, input int n_exp,
                             input bit stall, input int gap_len, input int exp_bubbles,
                             input string tag);
        int total, beat, pops, src, gap, last_hs, bubbles;
        int e_data, e_stab, e_rdy, e_last, inval_seen;
        bit tog, prev_stall, fin, inval_ok;
        logic [63:0] prev_data;
        logic prev_last, exp_rdy;
        total = n_exp * reps_cfg;
        beat = 0; pops = 0; src = 0; gap = 0; last_hs = -10; bubbles = 0;
        e_data = 0; e_stab = 0; e_rdy = 0; e_last = 0; inval_seen = 0;
        tog = 1'b1; prev_stall = 1'b0; fin = 1'b0; inval_ok = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        cfg_valid_i = 1'b1;
        cfg_blen_i = BlenW'(blen_cfg);
        cfg_reps_i = RepW'(reps_cfg);
        bc_valid_i = 1'b0;
        opnd_ready_i = 1'b1;
        @(negedge clk_i);
        check({tag, " cfg accepted"}, 64'(cfg_ready_o), 64'd1);
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            opnd_ready_i = stall ? tog : 1'b1;
            tog = !tog;
            bc_valid_i = !((src == 1 || src == 2) && gap < gap_len);
            bc_data_i = {~sc(src), sc(src)};
            @(negedge clk_i);
            if (opnd_valid_o) begin
                if (prev_stall && (opnd_data_o !== prev_data || opnd_last_o !== prev_last))
                    e_stab++;
                if (beat >= total || opnd_data_o !== {sc(beat / reps_cfg), sc(beat / reps_cfg)})
                    e_data++;
                if (opnd_last_o !== (beat == total - 1)) e_last++;
                exp_rdy = opnd_ready_i && (beat % reps_cfg == reps_cfg - 1) && (beat != total - 1);
                if (bc_ready_o !== exp_rdy || bc_invalidate_o || done_o) e_rdy++;
                prev_stall = !opnd_ready_i;
                prev_data = opnd_data_o;
                prev_last = opnd_last_o;
                if (opnd_ready_i) begin
                    beat++;
                    last_hs = cyc;
                end
            end else begin
                if (prev_stall) e_stab++;
                prev_stall = 1'b0;
                if (bc_invalidate_o) begin
                    inval_seen++;
                    fin = 1'b1;
                    inval_ok = done_o && bc_ready_o && beat == total && cyc == last_hs + 1;
                end else begin
                    if (beat > 0) bubbles++;
                    if (!bc_ready_o || done_o) e_rdy++;
                end
            end
            if (bc_ready_o && bc_valid_i && !bc_invalidate_o) begin
                pops++;
                src++;
                gap = 0;
            end else if (bc_ready_o && !bc_valid_i) begin
                gap++;
            end
            @(posedge clk_i); #1;
        end
        check({tag, " beats"}, 64'(beat), 64'(total));
        check({tag, " pops"}, 64'(pops), 64'(n_exp));
        check({tag, " data errors"}, 64'(e_data), 64'd0);
        check({tag, " stall stability errors"}, 64'(e_stab), 64'd0);
        check({tag, " last flag errors"}, 64'(e_last), 64'd0);
        check({tag, " ready rule errors"}, 64'(e_rdy), 64'd0);
        check({tag, " invalidate seen"}, 64'(inval_seen), 64'd1);
        check({tag, " invalidate timing"}, 64'(inval_ok), 64'd1);
        check({tag, " bubble cycles"}, 64'(bubbles), 64'(exp_bubbles));
        bc_valid_i = 1'b0;
        @(negedge clk_i);
        check({tag, " idle after round"}, 64'(cfg_ready_o), 64'd1);
        @(posedge clk_i); #1;
    endtask

    task automatic zero_round(input int blen_cfg, input int reps_cfg, input string tag);
        int dn, rd, iv, first;
        dn = 0; rd = 0; iv = 0; first = -1;
        cfg_valid_i = 1'b1;
        cfg_blen_i = BlenW'(blen_cfg);
        cfg_reps_i = RepW'(reps_cfg);
        bc_valid_i = 1'b1;
        bc_data_i = {Junk, S0};
        opnd_ready_i = 1'b1;
        @(negedge clk_i);
        check({tag, " cfg accepted"}, 64'(cfg_ready_o), 64'd1);
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (done_o) begin
                dn++;
                if (first < 0) first = c;
            end
            if (bc_ready_o || opnd_valid_o) rd++;
            if (bc_invalidate_o) iv++;
            @(posedge clk_i); #1;
        end
        check({tag, " done pulses"}, 64'(dn), 64'd1);
        check({tag, " done promptly"}, 64'(first >= 0 && first <= 1), 64'd1);
        check({tag, " bc/opnd traffic"}, 64'(rd), 64'd0);
        check({tag, " invalidate"}, 64'(iv), 64'd0);
        check({tag, " back to idle"}, 64'(cfg_ready_o), 64'd1);
        bc_valid_i = 1'b0;
    endtask

    initial begin
        int pops, beats;
        rst_ni = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_blen_i = '0;
        cfg_reps_i = '0;
        bc_valid_i = 1'b0;
        bc_data_i = '0;
        opnd_ready_i = 1'b0;

        tv[0] = '{3'b111, S0,   6'b100000, 32'h0};
        tv[1] = '{3'b011, S0,   6'b010000, 32'h0};
        tv[2] = '{3'b011, S1,   6'b001000, S0};
        tv[3] = '{3'b011, S1,   6'b011000, S0};
        tv[4] = '{3'b011, S2,   6'b001000, S1};
        tv[5] = '{3'b011, S2,   6'b011000, S1};
        tv[6] = '{3'b011, Junk, 6'b001000, S2};
        tv[7] = '{3'b011, Junk, 6'b001100, S2};
        tv[8] = '{3'b011, Junk, 6'b010011, 32'h0};
        tv[9] = '{3'b011, Junk, 6'b100000, 32'h0};

        #3;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Nominal round: blen=3, reps=2, source and sink always ready.
        cfg_blen_i = BlenW'(3);
        cfg_reps_i = RepW'(2);
        pops = 0;
        beats = 0;
        for (int i = 0; i < 10; i++) begin
            cfg_valid_i = tv[i].stim[2];
            bc_valid_i = tv[i].stim[1];
            opnd_ready_i = tv[i].stim[0];
            bc_data_i = {32'hA5A5_A5A5, tv[i].bc_d};
            @(negedge clk_i);
            check($sformatf("nominal row%0d flags", i),
                  64'({cfg_ready_o, bc_ready_o, opnd_valid_o, opnd_last_o, bc_invalidate_o,
                       done_o}), 64'(tv[i].flags));
            if (tv[i].flags[3])
                check($sformatf("nominal row%0d data", i), opnd_data_o,
                      {tv[i].scal, tv[i].scal});
            if (bc_ready_o && bc_valid_i && !bc_invalidate_o) pops++;
            if (opnd_valid_o && opnd_ready_i) beats++;
            @(posedge clk_i); #1;
        end
        check("nominal pops", 64'(pops), 64'd3);
        check("nominal beats", 64'(beats), 64'd6);
        cfg_valid_i = 1'b0;
        bc_valid_i = 1'b0;

        run_round(2, 3, 2, 1'b1, 0, 0, "backpressure");
        run_round(3, 2, 3, 1'b0, 5, 10, "starvation");
        zero_round(0, 4, "blen0");
        zero_round(3, 0, "reps0");
        run_round(40, 1, 32, 1'b0, 0, 0, "saturation");

        // Reset while serving rep 1 of 4 of the first scalar.
        cfg_valid_i = 1'b1;
        cfg_blen_i = BlenW'(2);
        cfg_reps_i = RepW'(4);
        bc_valid_i = 1'b1;
        bc_data_i = {Junk, S1};
        opnd_ready_i = 1'b1;
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        #1;
        check("pre-reset opnd_valid", 64'(opnd_valid_o), 64'd1);
        check("pre-reset opnd_data", opnd_data_o, {S1, S1});
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("mid-round reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        bc_valid_i = 1'b0;
        @(posedge clk_i); #1;
        run_round(1, 1, 1, 1'b0, 0, 0, "post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
